// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep sequencer: FSM state
// encoding, settle counter width and the vector-count helper.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Width of the settle counter; SETTLE is limited to 1..255.
    localparam int CNT_W = 8;

    // Number of input vectors for an N-input gate.
    function automatic int nv_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control/result bundle between a sweep requester and gate_sweep_ctrl.
// Optional checking signals exist only when GATE_SWEEP_CHECK_EN is defined.
interface gate_sweep_ctrl_if
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 3
);
    localparam int NV = nv_of(N_IN);

    logic          start;
    logic          busy;
    logic          done;
    logic [NV-1:0] truth;
`ifdef GATE_SWEEP_CHECK_EN
    logic [NV-1:0]   exp_tt;
    logic            mismatch;
    logic [N_IN-1:0] err_idx;

    modport master (output start, output exp_tt,
                    input busy, input done, input truth,
                    input mismatch, input err_idx);
    modport slave  (input start, input exp_tt,
                    output busy, output done, output truth,
                    output mismatch, output err_idx);
`else
    modport master (output start,
                    input busy, input done, input truth);
    modport slave  (input start,
                    output busy, output done, output truth);
`endif

endinterface

// File: rtl/gate_sweep_timer.sv
// Settle-time counter: cleared by load, counts while enabled, and flags
// expiry once the current vector has been held for SETTLE cycles.
module gate_sweep_timer
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    // Cycle counter; load wins over count so a new vector always starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign expired = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a small combinational gate.
// Steps dut_in through 0..NV-1, holds each vector SETTLE cycles, then
// samples dut_out into truth[idx]. Define GATE_SWEEP_CHECK_EN to compare
// each sample against a table latched at start.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    gate_sweep_ctrl_if.slave ctl,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out
);
    localparam int NV = nv_of(N_IN);
    // idx carries one extra bit so NV-1 is compared without wrapping.
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(NV - 1);
    localparam logic [N_IN:0] IDX_ONE  = (N_IN + 1)'(1);

    state_t          state_reg, state_next;
    logic [N_IN:0]   idx_reg;
    logic [NV-1:0]   truth_reg;
    logic            busy_reg;
    logic            timer_load;
    logic            timer_expired;
    logic            start_accept;
    logic [N_IN-1:0] vec_idx;

    assign start_accept = (state_reg == ST_IDLE) && ctl.start;
    assign vec_idx      = idx_reg[N_IN-1:0];

    // Counter restarts on a new sweep and after every sample.
    assign timer_load = start_accept || (state_reg == ST_SAMPLE);

    gate_sweep_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (state_reg == ST_SETTLE),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the sweep sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ctl.start) state_next = ST_SETTLE;
            ST_SETTLE: if (timer_expired) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Vector index, truth capture and busy flag; results hold after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            truth_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ctl.start) begin
                        idx_reg   <= '0;
                        truth_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    truth_reg[vec_idx] <= dut_out;
                    if (idx_reg != LAST_IDX) begin
                        idx_reg <= idx_reg + IDX_ONE;
                    end
                end
                ST_DONE: busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign dut_in    = vec_idx;
    assign ctl.truth = truth_reg;
    assign ctl.busy  = busy_reg;
    assign ctl.done  = (state_reg == ST_DONE);

`ifdef GATE_SWEEP_CHECK_EN
    logic [NV-1:0]   exp_reg;
    logic            mismatch_reg;
    logic [N_IN-1:0] err_idx_reg;

    // Compare each sample with the expected table; err_idx keeps the first miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_reg      <= '0;
            mismatch_reg <= 1'b0;
            err_idx_reg  <= '0;
        end else if (start_accept) begin
            exp_reg      <= ctl.exp_tt;
            mismatch_reg <= 1'b0;
            err_idx_reg  <= '0;
        end else if ((state_reg == ST_SAMPLE) && (dut_out != exp_reg[vec_idx])) begin
            mismatch_reg <= 1'b1;
            if (!mismatch_reg) begin
                err_idx_reg <= vec_idx;
            end
        end
    end

    assign ctl.mismatch = mismatch_reg;
    assign ctl.err_idx  = err_idx_reg;
`endif

endmodule
